writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Writer side of the 32-entry register file write port. Merges ALU results and
//  load-response data into the single registered write port (wr_en/rd/rd_value).
//  Loads win on collision; the losing ALU result parks in a 1-entry skid buffer,
//  which is exposed for operand forwarding. Also does load byte/half extraction
//  and sign extension, and keeps sticky error flags and a stall counter.
// PARAMETERS
//  XLEN   32  data width of results and rd_value
//  RD_W   32  width of rd output (register file rd port); bits [RD_W-1:5] driven 0
//  CNT_W  16  width of saturating stall counter
// PORTS
//  clk         in   1       clock, all state on posedge
//  rst         in   1       reset, asynchronous, active-high
//  alu_valid   in   1       ALU result offered
//  alu_ready   out  1       ALU result accepted when alu_valid&&alu_ready
//  alu_rd      in   5       ALU destination register
//  alu_value   in   XLEN    ALU result
//  ld_valid    in   1       load response present (not back-pressurable)
//  ld_rd       in   5       load destination register
//  ld_funct3   in   3       load type (RV32I encoding)
//  ld_addr_lo  in   2       byte address bits [1:0] of the load
//  ld_rdata    in   XLEN    raw aligned word from data memory
//  wr_en       out  1       register file write enable
//  rd          out  RD_W    register file write index
//  rd_value    out  XLEN    register file write data
//  fwd_valid   out  1       skid entry holds a pending write to nonzero reg
//  fwd_rd      out  5       skid destination
//  fwd_value   out  XLEN    skid data
//  err         out  2       sticky: [0] rd collision, [1] illegal/misaligned load
//  stall_cnt   out  CNT_W   saturating count of alu_valid&&!alu_ready cycles
// BEHAVIOUR
//  - Reset (async): wr_en=0, rd=0, rd_value=0, skid empty, fwd_* =0, err=0,
//    stall_cnt=0. Reset mid-operation discards skid contents; no write issued.
//  - alu_ready = !skid_full (registered state only; no comb path from ld_valid).
//  - Output write regs update every posedge; latency 1 cycle from accepted input.
//  - Select per cycle, priority: (1) ld_valid -> write load; (2) skid_full ->
//    write skid, skid empties; (3) accepted ALU -> write ALU; else wr_en=0.
//  - ld_valid with accepted ALU in same cycle: load written, ALU goes to skid.
//  - skid_full and ld_valid: load written, skid held (ALU still not ready).
//  - Skid state: EMPTY->FULL on ALU loss to load; FULL->EMPTY when drained.
//  - rd==0 from any source: handshake completes, wr_en=0 for that slot.
//  - Upstream guarantees ld_rd!=skid rd when both live; if violated (nonzero
//    rd equal): load written, skid entry dropped, err[0] set.
//  - Load extract: lane = ld_addr_lo. 000 LB sign-ext byte; 100 LBU zero-ext;
//    001 LH / 101 LHU half at ld_addr_lo[1], sign/zero-ext; 010 LW full word.
//    Funct3 011/110/111, LH/LHU with addr_lo[0]=1, LW with addr_lo!=0: no write,
//    err[1] set.
//  - err bits cleared only by rst. stall_cnt saturates at all-ones, no wrap.
//  - fwd_valid = skid_full && skid_rd!=0.
// TESTING
//  - ALU x5=0x1234 alone -> next cycle wr_en=1, rd=5, rd_value=0x1234; alu_ready=1.
//  - Same-cycle ALU x3=7 and LW x4 data 0xDEADBEEF -> cyc1 write x4=0xDEADBEEF,
//    fwd_valid=1 fwd_rd=3, alu_ready=0, stall_cnt+1 if alu_valid; cyc2 write x3=7.
//  - LB addr_lo=3 data 0x80FF0000 -> rd_value=0xFFFFFF80; LBU -> 0x00000080;
//    LHU addr_lo=2 -> 0x000080FF.
//  - ALU write to x0 and LW to x0 -> handshakes complete, wr_en stays 0.
//  - Skid x9 live, LW x9 -> x9=load data, skid dropped, err=2'b01; LH addr_lo=1
//    -> no write, err=2'b11; assert rst mid-skid -> all outputs 0 immediately.

Source files
------------

// File: rtl/writeback_if.sv
// writeback_if: ALU/load inputs and register-file write port of the writeback unit
interface writeback_if #(parameter int XLEN = 32, parameter int RD_W = 32, parameter int CNT_W = 16);
  logic             alu_valid;
  logic             alu_ready;
  logic [4:0]       alu_rd;
  logic [XLEN-1:0]  alu_value;
  logic             ld_valid;
  logic [4:0]       ld_rd;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_addr_lo;
  logic [XLEN-1:0]  ld_rdata;
  logic             wr_en;
  logic [RD_W-1:0]  rd;
  logic [XLEN-1:0]  rd_value;
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [XLEN-1:0]  fwd_value;
  logic [1:0]       err;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output alu_valid, alu_rd, alu_value, ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
    input  alu_ready, wr_en, rd, rd_value, fwd_valid, fwd_rd, fwd_value, err, stall_cnt
  );
  modport slave (
    input  alu_valid, alu_rd, alu_value, ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
    output alu_ready, wr_en, rd, rd_value, fwd_valid, fwd_rd, fwd_value, err, stall_cnt
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results and load data into one registered register-file write port
module writeback_unit #(
  parameter int XLEN  = 32,
  parameter int RD_W  = 32,
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  writeback_if.slave bus
);
  logic             r_skid_full, r_wr_en;
  logic [4:0]       r_skid_rd, r_rd;
  logic [XLEN-1:0]  r_skid_value, r_rd_value;
  logic [1:0]       r_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic             w_sext, w_ld_ok, w_alu_acc, w_coll;
  logic [XLEN-1:0]  w_ld_value;
  always_comb begin
    w_byte     = 8'(bus.ld_rdata >> {bus.ld_addr_lo, 3'b000});
    w_half     = bus.ld_addr_lo[1] ? bus.ld_rdata[31:16] : bus.ld_rdata[15:0];
    w_sext     = !bus.ld_funct3[2];
    w_ld_ok    = (bus.ld_funct3 == 3'b010) ? (bus.ld_addr_lo == 2'b00) :
                 (bus.ld_funct3[1:0] == 2'b01) ? !bus.ld_addr_lo[0] :
                 (bus.ld_funct3[1:0] == 2'b00);
    w_ld_value = (bus.ld_funct3[1:0] == 2'b00) ? {{(XLEN-8){w_sext && w_byte[7]}}, w_byte} :
                 (bus.ld_funct3[1:0] == 2'b01) ? {{(XLEN-16){w_sext && w_half[15]}}, w_half} :
                 bus.ld_rdata;
  end
  assign w_alu_acc = bus.alu_valid && !r_skid_full;
  // a legal load overwriting the parked register makes the older skid value stale
  assign w_coll    = bus.ld_valid && w_ld_ok && r_skid_full && r_skid_rd != 5'd0 && bus.ld_rd == r_skid_rd;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en      <= 1'b0;
      r_rd         <= 5'd0;
      r_rd_value   <= '0;
      r_skid_full  <= 1'b0;
      r_skid_rd    <= 5'd0;
      r_skid_value <= '0;
      r_err        <= 2'b00;
      r_stall_cnt  <= '0;
    end else begin
      if (bus.ld_valid) begin
        r_wr_en    <= w_ld_ok && bus.ld_rd != 5'd0;
        r_rd       <= bus.ld_rd;
        r_rd_value <= w_ld_value;
      end else if (r_skid_full) begin
        r_wr_en    <= r_skid_rd != 5'd0;
        r_rd       <= r_skid_rd;
        r_rd_value <= r_skid_value;
      end else begin
        r_wr_en    <= w_alu_acc && bus.alu_rd != 5'd0;
        r_rd       <= bus.alu_rd;
        r_rd_value <= bus.alu_value;
      end
      if (bus.ld_valid && w_alu_acc) begin
        r_skid_full  <= 1'b1;
        r_skid_rd    <= bus.alu_rd;
        r_skid_value <= bus.alu_value;
      end else if (w_coll || (!bus.ld_valid && r_skid_full)) begin
        r_skid_full <= 1'b0;
      end
      r_err <= r_err | {bus.ld_valid && !w_ld_ok, w_coll};
      if (bus.alu_valid && r_skid_full && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
  assign bus.alu_ready = !r_skid_full;
  assign bus.wr_en     = r_wr_en;
  assign bus.rd        = RD_W'(r_rd);
  assign bus.rd_value  = r_rd_value;
  assign bus.fwd_valid = r_skid_full && r_skid_rd != 5'd0;
  assign bus.fwd_rd    = r_skid_rd;
  assign bus.fwd_value = r_skid_value;
  assign bus.err       = r_err;
  assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed vector table plus hand-written skid, error and reset sequences
module tb_writeback_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  writeback_if #(.XLEN(32), .RD_W(32), .CNT_W(16)) bus ();
  writeback_unit #(.XLEN(32), .RD_W(32), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] aval;
    logic        lv;
    logic [4:0]  lrd;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] ldata;
    logic        ewr;
    logic [31:0] erd;
    logic [31:0] eval;
  } vec_t;
  vec_t v[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_value = '0;
    bus.ld_valid = 1'b0; bus.ld_rd = 5'd0; bus.ld_funct3 = 3'b010; bus.ld_addr_lo = 2'b00; bus.ld_rdata = '0;
  endtask
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] aval,
                       input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                       input logic [1:0] alo, input logic [31:0] ldata);
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_value = aval;
    bus.ld_valid = lv; bus.ld_rd = lrd; bus.ld_funct3 = f3; bus.ld_addr_lo = alo; bus.ld_rdata = ldata;
  endtask
  task automatic chk_wr(input string name, input logic ewr, input logic [31:0] erd, input logic [31:0] eval);
    chk({name, ".wr_en"}, 32'(bus.wr_en), 32'(ewr));
    if (ewr) begin
      chk({name, ".rd"}, bus.rd, erd);
      chk({name, ".rd_value"}, bus.rd_value, eval);
    end
  endtask
  initial begin
    v[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 5'd0,  3'b000, 2'd0, 32'h0,         1'b1, 32'd5,  32'h0000_1234};
    v[1] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 3'b000, 2'd3, 32'h80FF_0000, 1'b1, 32'd10, 32'hFFFF_FF80};
    v[2] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd11, 3'b100, 2'd3, 32'h80FF_0000, 1'b1, 32'd11, 32'h0000_0080};
    v[3] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd12, 3'b101, 2'd2, 32'h80FF_0000, 1'b1, 32'd12, 32'h0000_80FF};
    v[4] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd13, 3'b001, 2'd2, 32'h80FF_0000, 1'b1, 32'd13, 32'hFFFF_80FF};
    v[5] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd14, 3'b001, 2'd0, 32'h1234_7FFE, 1'b1, 32'd14, 32'h0000_7FFE};
    v[6] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd4,  3'b010, 2'd0, 32'hDEAD_BEEF, 1'b1, 32'd4,  32'hDEAD_BEEF};
    v[7] = '{1'b1, 5'd0,  32'h0000_00AA, 1'b0, 5'd0,  3'b000, 2'd0, 32'h0,         1'b0, 32'd0,  32'h0};
    v[8] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  3'b010, 2'd0, 32'h5555_AAAA, 1'b0, 32'd0,  32'h0};
    v[9] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  3'b010, 2'd0, 32'h0,         1'b0, 32'd0,  32'h0};
    idle();
    #12;
    chk("reset.wr_en", 32'(bus.wr_en), 32'd0);
    chk("reset.rd", bus.rd, 32'd0);
    chk("reset.rd_value", bus.rd_value, 32'd0);
    chk("reset.alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("reset.fwd_valid", 32'(bus.fwd_valid), 32'd0);
    chk("reset.err", 32'(bus.err), 32'd0);
    chk("reset.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      drive(v[i].av, v[i].ard, v[i].aval, v[i].lv, v[i].lrd, v[i].f3, v[i].alo, v[i].ldata);
      step();
      chk_wr($sformatf("vec%0d", i), v[i].ewr, v[i].erd, v[i].eval);
      chk($sformatf("vec%0d.alu_ready", i), 32'(bus.alu_ready), 32'd1);
    end
    // ALU loses to load, parks in skid, drains next cycle while a new ALU result stalls
    drive(1'b1, 5'd3, 32'd7, 1'b1, 5'd4, 3'b010, 2'd0, 32'hDEAD_BEEF);
    step();
    chk_wr("coll1", 1'b1, 32'd4, 32'hDEAD_BEEF);
    chk("coll1.fwd_valid", 32'(bus.fwd_valid), 32'd1);
    chk("coll1.fwd_rd", 32'(bus.fwd_rd), 32'd3);
    chk("coll1.fwd_value", bus.fwd_value, 32'd7);
    chk("coll1.alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("coll1.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    drive(1'b1, 5'd6, 32'd9, 1'b0, 5'd0, 3'b010, 2'd0, 32'h0);
    step();
    chk_wr("coll2", 1'b1, 32'd3, 32'd7);
    chk("coll2.fwd_valid", 32'(bus.fwd_valid), 32'd0);
    chk("coll2.alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("coll2.stall_cnt", 32'(bus.stall_cnt), 32'd1);
    step();
    chk_wr("coll3", 1'b1, 32'd6, 32'd9);
    idle();
    step();
    chk_wr("coll4", 1'b0, 32'd0, 32'd0);
    chk("coll4.err", 32'(bus.err), 32'd0);
    // skid held while a second load arrives, then drains
    drive(1'b1, 5'd20, 32'h2020, 1'b1, 5'd21, 3'b010, 2'd0, 32'h2121);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 3'b100, 2'd1, 32'h0000_AB00);
    step();
    chk_wr("hold1", 1'b1, 32'd22, 32'h0000_00AB);
    chk("hold1.fwd_rd", 32'(bus.fwd_valid ? bus.fwd_rd : 5'd0), 32'd20);
    idle();
    step();
    chk_wr("hold2", 1'b1, 32'd20, 32'h2020);
    // load to the parked register drops the skid entry and flags err[0]
    drive(1'b1, 5'd9, 32'd1, 1'b1, 5'd8, 3'b010, 2'd0, 32'h11);
    step();
    chk_wr("drop1", 1'b1, 32'd8, 32'h11);
    chk("drop1.fwd_rd", 32'(bus.fwd_valid ? bus.fwd_rd : 5'd0), 32'd9);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 3'b010, 2'd0, 32'hCAFE_0000);
    step();
    chk_wr("drop2", 1'b1, 32'd9, 32'hCAFE_0000);
    chk("drop2.fwd_valid", 32'(bus.fwd_valid), 32'd0);
    chk("drop2.err", 32'(bus.err), 32'd1);
    idle();
    step();
    chk_wr("drop3", 1'b0, 32'd0, 32'd0);
    // misaligned and illegal loads
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 3'b001, 2'd1, 32'hFFFF_FFFF);
    step();
    chk_wr("mis1", 1'b0, 32'd0, 32'd0);
    chk("mis1.err", 32'(bus.err), 32'd3);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 3'b011, 2'd0, 32'hFFFF_FFFF);
    step();
    chk_wr("mis2", 1'b0, 32'd0, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 3'b010, 2'd2, 32'hFFFF_FFFF);
    step();
    chk_wr("mis3", 1'b0, 32'd0, 32'd0);
    chk("mis3.err", 32'(bus.err), 32'd3);
    // asynchronous reset with a live skid entry
    drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd1, 3'b010, 2'd0, 32'h1111);
    step();
    chk("rst.pre_fwd", 32'(bus.fwd_valid), 32'd1);
    idle();
    rst = 1'b1;
    #1;
    chk("rst.wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst.rd", bus.rd, 32'd0);
    chk("rst.rd_value", bus.rd_value, 32'd0);
    chk("rst.fwd_valid", 32'(bus.fwd_valid), 32'd0);
    chk("rst.fwd_rd", 32'(bus.fwd_rd), 32'd0);
    chk("rst.fwd_value", bus.fwd_value, 32'd0);
    chk("rst.err", 32'(bus.err), 32'd0);
    chk("rst.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst.alu_ready", 32'(bus.alu_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_wr("rst.after", 1'b0, 32'd0, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
